// File: rtl/rx_pkg.sv
// rx_pkg: shared constants for the receive CP-removal / serial-to-parallel path.
// Holds the FFT size, sample width, flat frame width and the FSM state encoding
// used by rx_cp_remove_s2p and rx_sample_buffer.
package rx_pkg;

  localparam int N_FFT    = 16;
  localparam int SAMPLE_W = 16;
  localparam int IDX_W    = 4;
  localparam int FRAME_W  = SAMPLE_W * N_FFT;

  // FSM encoding, kept as plain constants for legacy tool compatibility.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SKIP_CP = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage

// File: rtl/rx_sample_buffer.sv
// rx_sample_buffer: 16-slot real/imag sample store, one slot written per enable.
// Latency: a write is visible on buf_real/buf_imag right after the capturing edge.
// Backpressure: none; the owner gates wr_en so the frame is frozen while held.
// Ports: clk, rst (async, active-high), wr_en, wr_idx (slot 0..15), wr_real,
//        wr_imag, buf_real/buf_imag (slot k at bits [16k+15:16k]).
module rx_sample_buffer
  import rx_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [SAMPLE_W-1:0] wr_real,
  input  logic [SAMPLE_W-1:0] wr_imag,
  output logic [FRAME_W-1:0]  buf_real,
  output logic [FRAME_W-1:0]  buf_imag
);

  // Storage is kept directly in packed form so the output needs no flattening.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_real <= '0;
      buf_imag <= '0;
    end else if (wr_en) begin
      buf_real[32'(wr_idx) * SAMPLE_W +: SAMPLE_W] <= wr_real;
      buf_imag[32'(wr_idx) * SAMPLE_W +: SAMPLE_W] <= wr_imag;
    end
  end

endmodule

// File: rtl/rx_cp_remove_s2p.sv
// rx_cp_remove_s2p: strips CP_LEN cyclic-prefix samples per OFDM symbol and
// gathers the next 16 samples into a parallel frame for the FFT core.
// Latency: out_valid rises right after the edge that captures sample 15.
// Backpressure: frame held until out_ready; samples arriving meanwhile are
// dropped with an overrun pulse.
// Ports: clk, rst (async, active-high), sym_start, sample_valid, in_real,
//        in_imag, out_ready, out_valid, out_real, out_imag, overrun, sym_err,
//        and overrun_cnt (8-bit) only when RX_OVERRUN_CNT_EN is defined.
// Optional feature macro: RX_OVERRUN_CNT_EN (saturating overrun counter).
module rx_cp_remove_s2p
  import rx_pkg::*;
#(
  parameter int CP_LEN = 1  // legal range 1..15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sym_start,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] in_real,
  input  logic [SAMPLE_W-1:0] in_imag,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [FRAME_W-1:0]  out_real,
  output logic [FRAME_W-1:0]  out_imag,
  output logic                overrun,
  output logic                sym_err
`ifdef RX_OVERRUN_CNT_EN
  ,
  output logic [7:0]          overrun_cnt
`endif
);

  // A symbol start consumes CP sample 0; with a one-sample CP that is the
  // whole prefix, so the FSM goes straight to collection.
  localparam logic [1:0]       START_STATE = (CP_LEN == 1) ? ST_COLLECT : ST_SKIP_CP;
  localparam logic [IDX_W-1:0] START_CNT   = (CP_LEN == 1) ? '0 : IDX_W'(1);
  localparam logic [IDX_W-1:0] CP_LAST     = IDX_W'(CP_LEN - 1);
  localparam logic [IDX_W-1:0] SLOT_LAST   = IDX_W'(N_FFT - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] cnt;
  logic             start;
  logic             wr_en;
  logic             handshake;

  assign start     = sample_valid & sym_start;
  assign out_valid = (state == ST_HOLD);
  assign handshake = out_valid & out_ready;

  // A sym_start sample is never stored: it is CP sample 0 of the next symbol.
  assign wr_en = (state == ST_COLLECT) & sample_valid & ~sym_start;

  rx_sample_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (cnt),
    .wr_real  (in_real),
    .wr_imag  (in_imag),
    .buf_real (out_real),
    .buf_imag (out_imag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
      sym_err <= 1'b0;
    end else begin
      overrun <= 1'b0;
      sym_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= START_STATE;
            cnt   <= START_CNT;
          end
        end

        ST_SKIP_CP: begin
          if (start) begin
            sym_err <= 1'b1;
            state   <= START_STATE;
            cnt     <= START_CNT;
          end else if (sample_valid) begin
            if (cnt == CP_LAST) begin
              state <= ST_COLLECT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_COLLECT: begin
          if (start) begin
            // Slots already written keep stale data until overwritten.
            sym_err <= 1'b1;
            state   <= START_STATE;
            cnt     <= START_CNT;
          end else if (sample_valid) begin
            if (cnt == SLOT_LAST) begin
              state <= ST_HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            // Handshake; a coinciding sym_start begins the next symbol now.
            // A plain sample on this cycle is discarded silently.
            if (start) begin
              state <= START_STATE;
              cnt   <= START_CNT;
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end else if (sample_valid) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef RX_OVERRUN_CNT_EN
  // Counts dropped samples per held frame; saturates, cleared by handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (handshake) begin
      overrun_cnt <= '0;
    end else if (out_valid && sample_valid && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_rx_cp_remove_s2p.sv
module tb_rx_cp_remove_s2p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sv [2];
  logic        ss [2];
  logic        rdy [2];
  logic [15:0] sr [2];
  logic [15:0] si [2];

  logic         ov [2];
  logic         ovr [2];
  logic         serr [2];
  logic [255:0] orl [2];
  logic [255:0] oim [2];
`ifdef RX_OVERRUN_CNT_EN
  logic [7:0]   ocnt [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int ovr_seen [2];
  int err_seen [2];

  rx_cp_remove_s2p #(.CP_LEN(1)) dut0 (
    .clk(clk), .rst(rst), .sym_start(ss[0]), .sample_valid(sv[0]),
    .in_real(sr[0]), .in_imag(si[0]), .out_ready(rdy[0]),
    .out_valid(ov[0]), .out_real(orl[0]), .out_imag(oim[0]),
    .overrun(ovr[0]), .sym_err(serr[0])
`ifdef RX_OVERRUN_CNT_EN
    , .overrun_cnt(ocnt[0])
`endif
  );

  rx_cp_remove_s2p #(.CP_LEN(4)) dut1 (
    .clk(clk), .rst(rst), .sym_start(ss[1]), .sample_valid(sv[1]),
    .in_real(sr[1]), .in_imag(si[1]), .out_ready(rdy[1]),
    .out_valid(ov[1]), .out_real(orl[1]), .out_imag(oim[1]),
    .overrun(ovr[1]), .sym_err(serr[1])
`ifdef RX_OVERRUN_CNT_EN
    , .overrun_cnt(ocnt[1])
`endif
  );

  // ---------------- behavioural model ----------------
  // Tracks the position of each valid sample within the current symbol:
  // positions below CP_LEN are prefix, the next 16 land in slots 0..15.
  bit          m_act [2];
  bit          m_hold [2];
  bit          m_ovr [2];
  bit          m_err [2];
  int          m_pos [2];
  int          m_oc [2];
  logic [15:0] m_br [2][16];
  logic [15:0] m_bi [2][16];

  function automatic int cp_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_hold[i] = 0; m_ovr[i] = 0; m_err[i] = 0;
      m_pos[i] = 0; m_oc[i] = 0;
      for (int k = 0; k < 16; k++) begin
        m_br[i][k] = '0;
        m_bi[i][k] = '0;
      end
    end
  endtask

  task automatic model_step(int i);
    bit st;
    int cp;
    cp = cp_of(i);
    st = sv[i] && ss[i];
    m_ovr[i] = 0;
    m_err[i] = 0;
    if (m_hold[i]) begin
      if (rdy[i]) begin
        m_hold[i] = 0;
        m_oc[i]   = 0;
        m_act[i]  = st;
        m_pos[i]  = st ? 1 : 0;
      end else if (sv[i]) begin
        m_ovr[i] = 1;
        if (m_oc[i] < 255) m_oc[i] = m_oc[i] + 1;
      end
    end else if (st) begin
      m_err[i] = m_act[i];
      m_act[i] = 1;
      m_pos[i] = 1;
    end else if (sv[i] && m_act[i]) begin
      if (m_pos[i] >= cp) begin
        m_br[i][m_pos[i] - cp] = sr[i];
        m_bi[i][m_pos[i] - cp] = si[i];
      end
      m_pos[i] = m_pos[i] + 1;
      if (m_pos[i] == cp + 16) begin
        m_hold[i] = 1;
        m_act[i]  = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  function automatic logic [255:0] frame(int i, bit imag);
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 16; k++)
      f[k*16 +: 16] = imag ? m_bi[i][k] : m_br[i][k];
    return f;
  endfunction

  task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d out_valid", i), 256'(ov[i]), 256'(m_hold[i]));
      chk($sformatf("dut%0d overrun", i), 256'(ovr[i]), 256'(m_ovr[i]));
      chk($sformatf("dut%0d sym_err", i), 256'(serr[i]), 256'(m_err[i]));
      chk($sformatf("dut%0d out_real", i), orl[i], frame(i, 0));
      chk($sformatf("dut%0d out_imag", i), oim[i], frame(i, 1));
`ifdef RX_OVERRUN_CNT_EN
      chk($sformatf("dut%0d overrun_cnt", i), 256'(ocnt[i]), 256'(m_oc[i]));
`endif
      if (ovr[i] === 1'b1) ovr_seen[i]++;
      if (serr[i] === 1'b1) err_seen[i]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int i, bit s, logic [15:0] r, logic [15:0] m);
    sv[i] = 1'b1; ss[i] = s; sr[i] = r; si[i] = m;
    tick();
    sv[i] = 1'b0; ss[i] = 1'b0;
  endtask

  // Full symbol on dut i: sym_start sample then CP_LEN-1+16 further samples,
  // the last 16 carrying real=base+k, imag=~(base+k), k=1..16.
  task automatic send_sym(int i, logic [15:0] base);
    send(i, 1'b1, 16'h7FFF, 16'h7FFF);
    for (int p = 1; p < cp_of(i); p++) send(i, 1'b0, 16'h5A5A, 16'hA5A5);
    for (int k = 1; k <= 16; k++) send(i, 1'b0, base + 16'(k), ~(base + 16'(k)));
  endtask

  initial begin
    int o0, e0;
    logic [15:0] v;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      sv[i] = 0; ss[i] = 0; rdy[i] = 0; sr[i] = '0; si[i] = '0;
      ovr_seen[i] = 0; err_seen[i] = 0;
    end
    rst = 1'b1;

    // Reset with random inputs.
    repeat (5) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        sv[i] = 1'($urandom); ss[i] = 1'($urandom); rdy[i] = 1'($urandom);
        sr[i] = 16'($urandom); si[i] = 16'($urandom);
      end
    end
    chk("reset out_valid", 256'(ov[0]), 256'(0));
    chk("reset out_real", orl[0], 256'(0));
    for (int i = 0; i < 2; i++) begin sv[i] = 0; ss[i] = 0; rdy[i] = 0; end
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post-reset idle", 256'(ov[0]), 256'(0));

    // Nominal, CP_LEN=1, out_ready=1.
    rdy[0] = 1'b1;
    send(0, 1'b1, 16'h7FFF, 16'h7FFF);
    for (int k = 1; k <= 16; k++) begin
      v = 16'(0 - k);
      send(0, 1'b0, 16'(k), v);
    end
    chk("nominal valid", 256'(ov[0]), 256'(1));
    chk("nominal slot0 re", 256'(orl[0][15:0]), 256'(16'd1));
    chk("nominal slot0 im", 256'(oim[0][15:0]), 256'(16'hFFFF));
    chk("nominal slot15 re", 256'(orl[0][255:240]), 256'(16'd16));
    chk("nominal slot15 im", 256'(oim[0][255:240]), 256'(16'hFFF0));
    tick();
    chk("nominal valid drop", 256'(ov[0]), 256'(0));

    // Backpressure: 5 cycles not ready in HOLD with 3 samples.
    rdy[0] = 1'b0;
    send_sym(0, 16'h0040);
    o0 = ovr_seen[0];
    send(0, 1'b0, 16'hAAAA, 16'hAAAA);
    tick();
    send(0, 1'b1, 16'hBBBB, 16'hBBBB);
    send(0, 1'b0, 16'hCCCC, 16'hCCCC);
    tick();
    chk("backpressure overruns", 256'(ovr_seen[0] - o0), 256'(3));
    chk("backpressure held", 256'(ov[0]), 256'(1));
    chk("backpressure slot0", 256'(orl[0][15:0]), 256'(16'h0041));
`ifdef RX_OVERRUN_CNT_EN
    chk("overrun_cnt before", 256'(ocnt[0]), 256'(3));
`endif
    rdy[0] = 1'b1;
    tick();
    chk("backpressure release", 256'(ov[0]), 256'(0));
`ifdef RX_OVERRUN_CNT_EN
    chk("overrun_cnt after", 256'(ocnt[0]), 256'(0));
`endif
    tick();

    // Abort after 7 collected samples, then a fresh symbol.
    e0 = err_seen[0];
    send(0, 1'b1, 16'h7FFF, 16'h7FFF);
    for (int k = 1; k <= 7; k++) send(0, 1'b0, 16'h0100 + 16'(k), 16'h0100);
    send_sym(0, 16'h0200);
    chk("abort sym_err once", 256'(err_seen[0] - e0), 256'(1));
    chk("abort slot0", 256'(orl[0][15:0]), 256'(16'h0201));
    chk("abort slot6", 256'(orl[0][111:96]), 256'(16'h0207));
    tick(); tick();

    // Gapped input on the CP_LEN=4 instance.
    rdy[1] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      send(1, n == 1, 16'(n), 16'h1000 + 16'(n));
      if (n == 19) chk("gapped not yet", 256'(ov[1]), 256'(0));
      if (n == 20) begin
        chk("gapped valid", 256'(ov[1]), 256'(1));
        chk("gapped slot0", 256'(orl[1][15:0]), 256'(16'd5));
        chk("gapped slot15", 256'(oim[1][255:240]), 256'(16'h1014));
      end
      tick(); tick();
    end

    // Back-to-back: next sym_start on the handshake cycle.
    o0 = ovr_seen[0];
    e0 = err_seen[0];
    send_sym(0, 16'h0300);
    send_sym(0, 16'h0400);
    chk("b2b valid", 256'(ov[0]), 256'(1));
    chk("b2b slot15", 256'(orl[0][255:240]), 256'(16'h0410));
    tick();
    chk("b2b no overrun", 256'(ovr_seen[0] - o0), 256'(0));
    chk("b2b no sym_err", 256'(err_seen[0] - e0), 256'(0));

    // Reset mid-COLLECT.
    send(0, 1'b1, 16'h7FFF, 16'h7FFF);
    for (int k = 1; k <= 5; k++) send(0, 1'b0, 16'h0500 + 16'(k), 16'h0500);
    rst = 1'b1;
    #1;
    chk("midreset valid", 256'(ov[0]), 256'(0));
    chk("midreset buffer", orl[0], 256'(0));
    tick();
    rst = 1'b0;
    tick();
    send_sym(0, 16'h0600);
    chk("after reset valid", 256'(ov[0]), 256'(1));
    chk("after reset slot0", 256'(orl[0][15:0]), 256'(16'h0601));
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
